// File: rtl/profile_dump_scheduler_pkg.sv
// profile_pkg: shared encodings for the val/rdy profiler and its dump scheduler.
//   KIND_*  : report word kind field (out_kind)
//   state_t : dump scheduler FSM states
package profile_pkg;

  localparam logic [1:0] KIND_IDLE  = 2'd0;
  localparam logic [1:0] KIND_STALL = 2'd1;
  localparam logic [1:0] KIND_XFER  = 2'd2;
  localparam logic [1:0] KIND_TOTAL = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/profile_chan_counter.sv
// profile_chan_counter: classifies one monitored val/rdy channel every cycle
// and accumulates idle / stall / transfer counts in saturating counters.
//   clk, rst     : clock, asynchronous active-low reset
//   val, rdy     : monitored channel handshake bits
//   clear        : zero the counters (this edge's sample is discarded)
//   snap_clear   : zero the counters at a dump snapshot (same effect as clear)
//   idle_cnt     : cycles with !val
//   stall_cnt    : cycles with val & !rdy
//   xfer_cnt     : cycles with val & rdy
module profile_chan_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             val,
  input  logic             rdy,
  input  logic             clear,
  input  logic             snap_clear,
  output logic [CNT_W-1:0] idle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic is_idle;
  logic is_stall;
  logic is_xfer;

  assign is_idle  = !val;
  assign is_stall = val && !rdy;
  assign is_xfer  = val && rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt  <= '0;
      stall_cnt <= '0;
      xfer_cnt  <= '0;
    end else if (clear || snap_clear) begin
      idle_cnt  <= '0;
      stall_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      // Exactly one class is true per cycle; each counter sticks at all-ones.
      if (is_idle && (idle_cnt != CNT_MAX))   idle_cnt  <= idle_cnt + 1'b1;
      if (is_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (is_xfer && (xfer_cnt != CNT_MAX))   xfer_cnt  <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/profile_dump_scheduler.sv
// profile_dump_scheduler: profiles N_CH val/rdy channels and, on request,
// snapshots all counters and streams them out one word per handshake.
//   clk, rst        : clock, asynchronous active-low reset
//   ch_val, ch_rdy  : monitored channel handshake bits
//   clear           : zero live counters
//   dump_req        : start a snapshot + dump (ignored while a dump runs)
//   dump_busy       : high from snapshot until the last word is accepted
//   out_val/out_rdy : report stream handshake
//   out_data        : counter value
//   out_ch          : channel of the word (0 for the total word)
//   out_kind        : 0 idle, 1 stall, 2 transfer, 3 total cycles
//   out_last        : final word of the dump
//   fsm_state       : scheduler state, for observation
//
// Report handshake: a word moves on any edge where out_val & out_rdy are both
// high. While out_val is high and out_rdy low, the word (data, ch, kind, last)
// is held unchanged; once out_val rises it stays high until that word moves.
module profile_dump_scheduler
  import profile_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 32,
  parameter int ID_W          = 2,
  parameter bit CLEAR_ON_DUMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_val,
  input  logic [N_CH-1:0]  ch_rdy,
  input  logic             clear,
  input  logic             dump_req,
  output logic             dump_busy,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] out_data,
  output logic [ID_W-1:0]  out_ch,
  output logic [1:0]       out_kind,
  output logic             out_last,
  output state_t           fsm_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  LAST_CH = ID_W'(N_CH - 1);

  state_t state;
  state_t state_nxt;
  logic   start;
  logic   advance;
  logic   snap_clear;

  // Word index is kept as (channel, kind); kind TOTAL marks the final word.
  logic [ID_W-1:0] cur_ch;
  logic [1:0]      cur_kind;

  logic [CNT_W-1:0] live_idle  [N_CH];
  logic [CNT_W-1:0] live_stall [N_CH];
  logic [CNT_W-1:0] live_xfer  [N_CH];
  logic [CNT_W-1:0] live_total;

  logic [CNT_W-1:0] shadow_idle  [N_CH];
  logic [CNT_W-1:0] shadow_stall [N_CH];
  logic [CNT_W-1:0] shadow_xfer  [N_CH];
  logic [CNT_W-1:0] shadow_total;

  assign snap_clear = start && CLEAR_ON_DUMP;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    profile_chan_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .val        (ch_val[g]),
      .rdy        (ch_rdy[g]),
      .clear      (clear),
      .snap_clear (snap_clear),
      .idle_cnt   (live_idle[g]),
      .stall_cnt  (live_stall[g]),
      .xfer_cnt   (live_xfer[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_total <= '0;
    end else if (clear || snap_clear) begin
      live_total <= '0;
    end else if (live_total != CNT_MAX) begin
      live_total <= live_total + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state and control strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (dump_req) begin
          start     = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (out_rdy) begin
          advance = 1'b1;
          if (cur_kind == KIND_TOTAL) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Snapshot takes the registered live values, so the snapshot edge's own
  // sample is never part of the dump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_idle[i]  <= '0;
        shadow_stall[i] <= '0;
        shadow_xfer[i]  <= '0;
      end
      shadow_total <= '0;
    end else if (start) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_idle[i]  <= live_idle[i];
        shadow_stall[i] <= live_stall[i];
        shadow_xfer[i]  <= live_xfer[i];
      end
      shadow_total <= live_total;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ch   <= '0;
      cur_kind <= KIND_IDLE;
    end else if (start) begin
      cur_ch   <= '0;
      cur_kind <= KIND_IDLE;
    end else if (advance) begin
      if (cur_kind == KIND_XFER) begin
        if (cur_ch == LAST_CH) begin
          cur_ch   <= '0;
          cur_kind <= KIND_TOTAL;
        end else begin
          cur_ch   <= cur_ch + 1'b1;
          cur_kind <= KIND_IDLE;
        end
      end else begin
        // From TOTAL this wraps to IDLE as the FSM returns to S_IDLE.
        cur_kind <= cur_kind + 2'd1;
      end
    end
  end

  assign out_val   = (state == S_SEND);
  assign dump_busy = (state == S_SEND);
  assign fsm_state = state;

  // Output fields are forced to zero outside a dump.
  always_comb begin
    out_data = '0;
    out_ch   = '0;
    out_kind = KIND_IDLE;
    out_last = 1'b0;
    if (state == S_SEND) begin
      out_ch   = cur_ch;
      out_kind = cur_kind;
      out_last = (cur_kind == KIND_TOTAL);
      case (cur_kind)
        KIND_IDLE:  out_data = shadow_idle[cur_ch];
        KIND_STALL: out_data = shadow_stall[cur_ch];
        KIND_XFER:  out_data = shadow_xfer[cur_ch];
        default:    out_data = shadow_total;
      endcase
    end
  end

endmodule

// File: tb/tb_profile_dump_scheduler.sv
// Bench for profile_dump_scheduler. Three instances share channel stimulus,
// clear, reset and out_rdy; each has its own dump_req:
//   d0: defaults, d1: CNT_W=4, d2: CLEAR_ON_DUMP=0.
// Expected report words are pushed as {last, kind, ch, data[31:0]}.
module tb_profile_dump_scheduler;
  import profile_pkg::*;

  localparam int W = 37;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_val;
  logic [3:0] ch_rdy;
  logic       clear;
  logic       out_rdy;
  logic [2:0] dump_req;

  logic [2:0]  busy_v;
  logic [2:0]  oval_v;
  logic [2:0]  olast_v;
  logic [1:0]  och_v   [3];
  logic [1:0]  okind_v [3];
  logic [31:0] odata_v [3];
  logic [31:0] odata0;
  logic [3:0]  odata1;
  logic [31:0] odata2;
  state_t      st0, st1, st2;

  assign odata_v[0] = odata0;
  assign odata_v[1] = {28'd0, odata1};
  assign odata_v[2] = odata2;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit           held      [3];
  logic [W-1:0] held_word [3];
  int           val_cycles[3];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  profile_dump_scheduler u_d0 (
    .clk(clk), .rst(rst), .ch_val(ch_val), .ch_rdy(ch_rdy), .clear(clear),
    .dump_req(dump_req[0]), .dump_busy(busy_v[0]), .out_val(oval_v[0]),
    .out_rdy(out_rdy), .out_data(odata0), .out_ch(och_v[0]),
    .out_kind(okind_v[0]), .out_last(olast_v[0]), .fsm_state(st0)
  );

  profile_dump_scheduler #(.CNT_W(4)) u_d1 (
    .clk(clk), .rst(rst), .ch_val(ch_val), .ch_rdy(ch_rdy), .clear(clear),
    .dump_req(dump_req[1]), .dump_busy(busy_v[1]), .out_val(oval_v[1]),
    .out_rdy(out_rdy), .out_data(odata1), .out_ch(och_v[1]),
    .out_kind(okind_v[1]), .out_last(olast_v[1]), .fsm_state(st1)
  );

  profile_dump_scheduler #(.CLEAR_ON_DUMP(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .ch_val(ch_val), .ch_rdy(ch_rdy), .clear(clear),
    .dump_req(dump_req[2]), .dump_busy(busy_v[2]), .out_val(oval_v[2]),
    .out_rdy(out_rdy), .out_data(odata2), .out_ch(och_v[2]),
    .out_kind(okind_v[2]), .out_last(olast_v[2]), .fsm_state(st2)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_word(input int d, input logic [31:0] data, input logic [1:0] ch,
                           input logic [1:0] kind, input logic last);
    logic [W-1:0] v;
    v = {last, kind, ch, data};
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic push_uniform(input int d, input int idle, input int stall, input int xfer,
                              input int total);
    for (int c = 0; c < 4; c++) begin
      push_word(d, idle,  2'(c), KIND_IDLE,  1'b0);
      push_word(d, stall, 2'(c), KIND_STALL, 1'b0);
      push_word(d, xfer,  2'(c), KIND_XFER,  1'b0);
    end
    push_word(d, total, 2'd0, KIND_TOTAL, 1'b1);
  endtask

  task automatic mon(input int d);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    got = {olast_v[d], okind_v[d], och_v[d], odata_v[d]};
    if (!rst) begin
      held[d] = 1'b0;
      return;
    end
    if (oval_v[d]) val_cycles[d]++;
    if (held[d] && oval_v[d]) check($sformatf("hold_d%0d", d), got, held_word[d]);
    if (oval_v[d] && out_rdy) begin
      if (qsize(d) == 0) begin
        n_checks++;
        $display("FAIL unexpected_word_d%0d: got %h expected none", d, got);
      end else begin
        case (d)
          0:       exp = exp_q0.pop_front();
          1:       exp = exp_q1.pop_front();
          default: exp = exp_q2.pop_front();
        endcase
        check($sformatf("word_d%0d", d), got, exp);
      end
    end
    held[d]      = oval_v[d] && !out_rdy;
    held_word[d] = got;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) mon(d);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    ch_val   = '0;
    ch_rdy   = '0;
    clear    = 1'b0;
    dump_req = '0;
    out_rdy  = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic run_dump(input int d, input bit toggle);
    bit done;
    dump_req[d] = 1'b1;
    out_rdy     = toggle ? 1'b0 : 1'b1;
    step(1);
    dump_req[d] = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy_v[d]) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        if (toggle) out_rdy = ~out_rdy;
      end
    end
    check($sformatf("dump_done_d%0d", d), W'(done), W'(1));
    check($sformatf("queue_empty_d%0d", d), W'(qsize(d)), W'(0));
  endtask

  task automatic drive_t1_pattern();
    // ch0 idle, ch1 stall, ch2 transfer, ch3 alternating transfer/idle
    ch_rdy = 4'b1100;
    for (int k = 0; k < 10; k++) begin
      ch_val = {(k % 2 == 0), 3'b110};
      step(1);
    end
    ch_val = '0;
  endtask

  task automatic push_t1(input int d);
    int ti[4];
    int ts[4];
    int tx[4];
    ti = '{10, 0, 0, 5};
    ts = '{0, 10, 0, 0};
    tx = '{0, 0, 10, 5};
    for (int c = 0; c < 4; c++) begin
      push_word(d, ti[c], 2'(c), KIND_IDLE,  1'b0);
      push_word(d, ts[c], 2'(c), KIND_STALL, 1'b0);
      push_word(d, tx[c], 2'(c), KIND_XFER,  1'b0);
    end
    push_word(d, 10, 2'd0, KIND_TOTAL, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b0;
    ch_val   = '0;
    ch_rdy   = '0;
    clear    = 1'b0;
    dump_req = '0;
    out_rdy  = 1'b0;
    #3;
    check("rst_out_val",   W'(oval_v),      W'(0));
    check("rst_dump_busy", W'(busy_v),      W'(0));
    check("rst_out_last",  W'(olast_v),     W'(0));
    check("rst_out_data",  W'(odata0),      W'(0));
    check("rst_state",     W'(st0),         W'(S_IDLE));

    // 1: basic classification, out_rdy always high
    do_reset();
    push_t1(0);
    drive_t1_pattern();
    val_cycles[0] = 0;
    run_dump(0, 1'b0);
    check("t1_val_cycles", W'(val_cycles[0]), W'(13));
    check("t1_busy_low",   W'(busy_v[0]),     W'(0));

    // 2: same with back-pressure toggling
    do_reset();
    push_t1(0);
    drive_t1_pattern();
    run_dump(0, 1'b1);

    // 3: saturation with 4-bit counters
    do_reset();
    step(20);
    push_uniform(1, 15, 0, 0, 15);
    run_dump(1, 1'b0);

    // 4: dump_req + clear mid-dump
    do_reset();
    step(6);
    push_uniform(0, 6, 0, 0, 6);
    out_rdy     = 1'b1;
    dump_req[0] = 1'b1;
    step(1);
    dump_req[0] = 1'b0;
    step(3);
    dump_req[0] = 1'b1;
    clear       = 1'b1;
    step(1);
    dump_req[0] = 1'b0;
    clear       = 1'b0;
    ch_val[2]   = 1'b1;
    ch_rdy[2]   = 1'b1;
    step(7);
    ch_val[2] = 1'b0;
    step(2);
    check("t4_first_done", W'(busy_v[0]), W'(0));
    check("t4_queue_empty", W'(qsize(0)), W'(0));
    for (int c = 0; c < 4; c++) begin
      push_word(0, (c == 2) ? 2 : 9, 2'(c), KIND_IDLE, 1'b0);
      push_word(0, 0, 2'(c), KIND_STALL, 1'b0);
      push_word(0, (c == 2) ? 7 : 0, 2'(c), KIND_XFER, 1'b0);
    end
    push_word(0, 9, 2'd0, KIND_TOTAL, 1'b1);
    run_dump(0, 1'b0);
    step(5);
    check("t4_no_extra_dump", W'(oval_v[0]), W'(0));

    // 5: asynchronous reset mid-dump
    do_reset();
    step(4);
    push_uniform(0, 4, 0, 0, 4);
    out_rdy     = 1'b1;
    dump_req[0] = 1'b1;
    step(1);
    dump_req[0] = 1'b0;
    step(6);
    #2;
    rst = 1'b0;
    #1;
    check("t5_abort_val",  W'(oval_v[0]), W'(0));
    check("t5_abort_busy", W'(busy_v[0]), W'(0));
    exp_q0.delete();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    ch_val[1] = 1'b1;
    ch_rdy[1] = 1'b0;
    step(3);
    ch_val = '0;
    for (int c = 0; c < 4; c++) begin
      push_word(0, (c == 1) ? 0 : 3, 2'(c), KIND_IDLE, 1'b0);
      push_word(0, (c == 1) ? 3 : 0, 2'(c), KIND_STALL, 1'b0);
      push_word(0, 0, 2'(c), KIND_XFER, 1'b0);
    end
    push_word(0, 3, 2'd0, KIND_TOTAL, 1'b1);
    run_dump(0, 1'b0);

    // 6: CLEAR_ON_DUMP=0 keeps counting across the snapshot
    do_reset();
    step(10);
    push_uniform(2, 10, 0, 0, 10);
    run_dump(2, 1'b0);
    // counted so far: 10 + snapshot edge + 13 transfer edges = 24 idle
    ch_val[0] = 1'b1;
    ch_rdy[0] = 1'b1;
    step(1);
    ch_val = '0;
    ch_rdy = '0;
    for (int c = 0; c < 4; c++) begin
      push_word(2, (c == 0) ? 24 : 25, 2'(c), KIND_IDLE, 1'b0);
      push_word(2, 0, 2'(c), KIND_STALL, 1'b0);
      push_word(2, (c == 0) ? 1 : 0, 2'(c), KIND_XFER, 1'b0);
    end
    push_word(2, 25, 2'd0, KIND_TOTAL, 1'b1);
    run_dump(2, 1'b0);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
